// File: rtl/jtkicker_rom_slot_if.sv
// Bundle of the renderer-side ROM port and the SDRAM-controller port of one ROM slot.
// The slave modport is the slot itself; the master modport is whatever drives it
// (renderer plus SDRAM controller, or a testbench standing in for both).
interface jtkicker_rom_slot_if #(
    parameter int AW  = 13,
    parameter int SDW = 22
) ();
    logic            flush;
    logic [AW-1:0]   rom_addr;
    logic            rom_cs;
    logic            rom_ok;
    logic [31:0]     rom_data;
    logic [SDW-1:0]  sdram_addr;
    logic            sdram_req;
    logic            sdram_ack;
    logic            sdram_rdy;
    logic [15:0]     sdram_din;

    modport master (
        output flush, rom_addr, rom_cs, sdram_ack, sdram_rdy, sdram_din,
        input  rom_ok, rom_data, sdram_addr, sdram_req
    );

    modport slave (
        input  flush, rom_addr, rom_cs, sdram_ack, sdram_rdy, sdram_din,
        output rom_ok, rom_data, sdram_addr, sdram_req
    );
endinterface

// File: rtl/jtkicker_rom_slot.sv
// SDRAM-side responder for a 32-bit graphics ROM client. Hits in a two-entry word
// cache answer in the same cycle; a miss fetches the word as two 16-bit beats
// (low half first) and fills the entry selected by a round-robin victim pointer.
module jtkicker_rom_slot #(
    parameter int             AW     = 13,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jtkicker_rom_slot_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [SDW-1:0]  sdram_addr_q, sdram_addr_d;
    logic            sdram_req_q, sdram_req_d;
    logic [15:0]     lo_q, lo_d;
    logic            victim_q, victim_d;
    // Set when a flush lands while a fetch is in flight, so that fill is dropped.
    logic            discard_q, discard_d;

    logic            valid_q [2];
    logic            valid_d [2];
    logic [AW-1:0]   tag_q   [2];
    logic [AW-1:0]   tag_d   [2];
    logic [31:0]     data_q  [2];
    logic [31:0]     data_d  [2];

    logic [1:0]      hit;
    logic            hit_any;
    logic            fill;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hit
            assign hit[gi] = valid_q[gi] && (tag_q[gi] == bus.rom_addr);
        end
    endgenerate

    assign hit_any = |hit;

    // Client-facing outputs are combinational so a hit costs no wait state.
    always_comb begin
        bus.rom_ok     = bus.rom_cs && hit_any;
        bus.rom_data   = hit[1] ? data_q[1] : data_q[0];
        bus.sdram_addr = sdram_addr_q;
        bus.sdram_req  = sdram_req_q;
    end

    // State register plus all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
            lo_q         <= '0;
            victim_q     <= 1'b0;
            discard_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
            lo_q         <= lo_d;
            victim_q     <= victim_d;
            discard_q    <= discard_d;
            for (int i = 0; i < 2; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Next-state logic: a started fetch always runs to the second beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.rom_cs && !hit_any && !bus.flush) state_d = REQ;
            REQ:     if (bus.sdram_ack) state_d = bus.sdram_rdy ? BEAT1 : BEAT0;
            BEAT0:   if (bus.sdram_rdy) state_d = BEAT1;
            BEAT1:   if (bus.sdram_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: request launch, beat capture, cache fill and flush.
    always_comb begin
        req_addr_d   = req_addr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        lo_d         = lo_q;
        victim_d     = victim_q;
        discard_d    = discard_q;
        for (int i = 0; i < 2; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            data_d[i]  = data_q[i];
        end

        if (state_q == IDLE && state_d == REQ) begin
            req_addr_d   = bus.rom_addr;
            // Sum wraps modulo 2^SDW by truncation.
            sdram_addr_d = OFFSET + SDW'({bus.rom_addr, 1'b0});
            sdram_req_d  = 1'b1;
            discard_d    = 1'b0;
        end

        if (state_q == REQ && bus.sdram_ack) begin
            sdram_req_d = 1'b0;
            if (bus.sdram_rdy) lo_d = bus.sdram_din;
        end

        if (state_q == BEAT0 && bus.sdram_rdy) lo_d = bus.sdram_din;

        if (bus.flush && state_q != IDLE) discard_d = 1'b1;

        fill = (state_q == BEAT1) && bus.sdram_rdy && !discard_q && !bus.flush;
        if (fill) victim_d = ~victim_q;

        for (int i = 0; i < 2; i++) begin
            if (bus.flush) begin
                valid_d[i] = 1'b0;
            end else if (fill && victim_q == 1'(i)) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = req_addr_q;
                data_d[i]  = {bus.sdram_din, lo_q};
            end
        end
    end
endmodule

// File: tb/tb_jtkicker_rom_slot.sv
// Directed bench for jtkicker_rom_slot: reset, miss/fill, hit, eviction,
// address change mid-fetch, flush mid-fetch and reset mid-request.
module tb_jtkicker_rom_slot;
    localparam int          AW     = 13;
    localparam int          SDW    = 22;
    // Non-zero base close to the top so that address wrap-around is exercised.
    localparam logic [21:0] OFFSET = 22'h3FFFF0;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    jtkicker_rom_slot_if #(.AW(AW), .SDW(SDW)) bus ();

    jtkicker_rom_slot #(.AW(AW), .SDW(SDW), .OFFSET(OFFSET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) at falling edges for sdram_req to be high.
    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.sdram_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack();
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = d;
        @(negedge clk);
        bus.sdram_rdy = 1'b0;
    endtask

    task automatic serve(input logic [15:0] lo, input logic [15:0] hi);
        $display("fetch sdram_addr=%06h beats %04h %04h", bus.sdram_addr, lo, hi);
        do_ack();
        beat(lo);
        beat(hi);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.flush = 1'b0; bus.rom_cs = 1'b1; bus.rom_addr = '0;
        bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_din = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.sdram_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", bus.sdram_req); else passed++;
        checks++; if (bus.sdram_addr !== 22'h0) $display("FAIL reset_addr got=%h exp=0", bus.sdram_addr); else passed++;
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL reset_ok got=%0b exp=0", bus.rom_ok); else passed++;
        checks++; if (bus.rom_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", bus.rom_data); else passed++;
        bus.rom_cs = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_miss_fill();
        bit got;
        bus.rom_cs = 1'b1; bus.rom_addr = 13'h0010;
        wait_req(got);
        checks++; if (got !== 1'b1) $display("FAIL t1_req got=%0b exp=1", got); else passed++;
        checks++; if (bus.sdram_addr !== 22'(OFFSET + 22'h20)) $display("FAIL t1_addr got=%h exp=%h", bus.sdram_addr, 22'(OFFSET + 22'h20)); else passed++;
        @(negedge clk);
        checks++; if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h20)) $display("FAIL t1_hold req=%0b addr=%h exp req=1 addr=%h", bus.sdram_req, bus.sdram_addr, 22'(OFFSET + 22'h20)); else passed++;
        do_ack();
        beat(16'hBEEF);
        checks++; if (bus.rom_ok !== 1'b0 || bus.sdram_req !== 1'b0) $display("FAIL t1_mid ok=%0b req=%0b exp 0 0", bus.rom_ok, bus.sdram_req); else passed++;
        beat(16'hDEAD);
        checks++; if (bus.rom_ok !== 1'b1) $display("FAIL t1_ok got=%0b exp=1", bus.rom_ok); else passed++;
        checks++; if (bus.rom_data !== 32'hDEADBEEF) $display("FAIL t1_data got=%h exp=deadbeef", bus.rom_data); else passed++;
        @(negedge clk);
        checks++; if (bus.sdram_req !== 1'b0) $display("FAIL t1_noreq got=%0b exp=0", bus.sdram_req); else passed++;
        $display("test1 word 0010 done");
    endtask

    task automatic test_hit();
        bit got;
        bus.rom_addr = 13'h0011;
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h22)) $display("FAIL t2_req got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h22)); else passed++;
        serve(16'h5678, 16'h1234);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'h12345678) $display("FAIL t2_fill ok=%0b data=%h exp 1 12345678", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_addr = 13'h0010;
        #1;
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'hDEADBEEF) $display("FAIL t2_hit ok=%0b data=%h exp 1 deadbeef", bus.rom_ok, bus.rom_data); else passed++;
        @(negedge clk);
        checks++; if (bus.sdram_req !== 1'b0) $display("FAIL t2_noreq got=%0b exp=0", bus.sdram_req); else passed++;
        $display("test2 hit 0010 done");
    endtask

    task automatic test_evict();
        bit got;
        bus.rom_addr = 13'h0012;
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h24)) $display("FAIL t3_req got=%0b addr=%h", got, bus.sdram_addr); else passed++;
        serve(16'h3333, 16'h4444);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'h44443333) $display("FAIL t3_fill ok=%0b data=%h exp 1 44443333", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_addr = 13'h0011;
        #1;
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'h12345678) $display("FAIL t3_keep ok=%0b data=%h exp 1 12345678", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_addr = 13'h0010;
        #1;
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL t3_evicted ok=%0b exp=0", bus.rom_ok); else passed++;
        @(negedge clk);
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h20)) $display("FAIL t3_refetch got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h20)); else passed++;
        serve(16'hBEEF, 16'hDEAD);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'hDEADBEEF) $display("FAIL t3_refill ok=%0b data=%h exp 1 deadbeef", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_addr = 13'h0011;
        #1;
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL t3_evict2 ok=%0b exp=0", bus.rom_ok); else passed++;
        bus.rom_cs = 1'b0;
        @(negedge clk);
        $display("test3 eviction done");
    endtask

    task automatic test_addr_change();
        bit got;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.rom_cs = 1'b1; bus.rom_addr = 13'h0020;
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h40)) $display("FAIL t4_req got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h40)); else passed++;
        do_ack();
        bus.rom_addr = 13'h0021;
        beat(16'hAAAA);
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL t4_mid ok=%0b exp=0", bus.rom_ok); else passed++;
        beat(16'hBBBB);
        checks++; if (bus.rom_ok !== 1'b0 || bus.sdram_req !== 1'b0) $display("FAIL t4_after ok=%0b req=%0b exp 0 0", bus.rom_ok, bus.sdram_req); else passed++;
        @(negedge clk);
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h42)) $display("FAIL t4_newreq got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h42)); else passed++;
        serve(16'hCCCC, 16'hDDDD);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'hDDDDCCCC) $display("FAIL t4_fill ok=%0b data=%h exp 1 ddddcccc", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_addr = 13'h0020;
        #1;
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'hBBBBAAAA) $display("FAIL t4_cached ok=%0b data=%h exp 1 bbbbaaaa", bus.rom_ok, bus.rom_data); else passed++;
        @(negedge clk);
        $display("test4 address change done");
    endtask

    task automatic test_flush();
        bit got;
        bus.rom_addr = 13'h0030;
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h60)) $display("FAIL t5_req got=%0b addr=%h", got, bus.sdram_addr); else passed++;
        do_ack();
        beat(16'h1111);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.rom_addr = 13'h0020;
        #1;
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL t5_cleared ok=%0b exp=0", bus.rom_ok); else passed++;
        bus.rom_addr = 13'h0030;
        beat(16'h2222);
        checks++; if (bus.rom_ok !== 1'b0) $display("FAIL t5_discard ok=%0b exp=0", bus.rom_ok); else passed++;
        @(negedge clk);
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h60)) $display("FAIL t5_remiss got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h60)); else passed++;
        serve(16'h1111, 16'h2222);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'h22221111) $display("FAIL t5_fill ok=%0b data=%h exp 1 22221111", bus.rom_ok, bus.rom_data); else passed++;
        $display("test5 flush done");
    endtask

    task automatic test_reset_mid();
        bit got;
        bus.rom_addr = 13'h0040;
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h80)) $display("FAIL t6_req got=%0b addr=%h", got, bus.sdram_addr); else passed++;
        bus.rom_addr = 13'h0030;
        #1;
        checks++; if (bus.rom_ok !== 1'b1) $display("FAIL t6_prehit ok=%0b exp=1", bus.rom_ok); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sdram_req !== 1'b0 || bus.rom_ok !== 1'b0) $display("FAIL t6_async req=%0b ok=%0b exp 0 0", bus.sdram_req, bus.rom_ok); else passed++;
        bus.rom_addr = 13'h0040;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_req(got);
        checks++; if (got !== 1'b1 || bus.sdram_addr !== 22'(OFFSET + 22'h80)) $display("FAIL t6_refetch got=%0b addr=%h exp addr=%h", got, bus.sdram_addr, 22'(OFFSET + 22'h80)); else passed++;
        serve(16'h5555, 16'h6666);
        checks++; if (bus.rom_ok !== 1'b1 || bus.rom_data !== 32'h66665555) $display("FAIL t6_fill ok=%0b data=%h exp 1 66665555", bus.rom_ok, bus.rom_data); else passed++;
        bus.rom_cs = 1'b0;
        @(negedge clk);
        $display("test6 reset mid-request done");
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_evict();
        test_addr_change();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
